// File: rtl/robot_pkg.sv
// Shared types and constants for the robot motion controller.
package robot_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FWD  = 3'd1,
    SLOW = 3'd2,
    STOP = 3'd3,
    TURN = 3'd4
  } state_e;

  localparam logic [1:0] SPD_HALT = 2'd0;
  localparam logic [1:0] SPD_SLOW = 2'd1;
  localparam logic [1:0] SPD_FULL = 2'd3;

  localparam int SAFE_DIST_DEF   = 100;
  localparam int WARN_DIST_DEF   = 300;
  localparam int TURN_CYCLES_DEF = 8;

  function automatic logic [1:0] speed_of(input state_e s);
    logic [1:0] spd;
    case (s)
      FWD:     spd = SPD_FULL;
      SLOW:    spd = SPD_SLOW;
      TURN:    spd = SPD_SLOW;
      default: spd = SPD_HALT;
    endcase
    return spd;
  endfunction

endpackage

// File: rtl/robot_ctrl_if.sv
// Sensor-in / motor-out signal bundle between front-end, controller and PWM block.
interface robot_ctrl_if #(
  parameter int DIST_W = 16
);
  logic [DIST_W-1:0] dist_v;
  logic [1:0]        speed_o;
  logic              turn_o;
  logic [2:0]        state_o;
  logic              obstacle_o;

  modport master (output dist_v, input speed_o, turn_o, state_o, obstacle_o);
  modport slave  (input dist_v, output speed_o, turn_o, state_o, obstacle_o);
endinterface

// File: rtl/robot_turn_timer.sv
// Loadable down-counter timing one turn manoeuvre; saturates at zero.
module robot_turn_timer #(
  parameter int CNT_W = 4,
  parameter int MAX_V = 7
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Counter register: load wins over decrement.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != {CNT_W{1'b0}})) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == {CNT_W{1'b0}});

`ifdef FORMAL
  robot_turn_timer_props #(.CNT_W(CNT_W), .MAX_V(MAX_V)) u_props (
    .clk(clk), .rstn(rstn), .i_cnt(r_cnt)
  );
`endif

endmodule

`ifdef FORMAL
module robot_turn_timer_props #(
  parameter int CNT_W = 4,
  parameter int MAX_V = 7
) (
  input logic             clk,
  input logic             rstn,
  input logic [CNT_W-1:0] i_cnt
);
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rstn)
    i_cnt <= CNT_W'(MAX_V));
endmodule
`endif

// File: rtl/robot_ctrl.sv
// Obstacle-avoidance FSM: samples distance each clock, drives registered motor commands.
module robot_ctrl
  import robot_pkg::*;
#(
  parameter int DIST_W      = 16,
  parameter int SAFE_DIST   = SAFE_DIST_DEF,
  parameter int WARN_DIST   = WARN_DIST_DEF,
  parameter int TURN_CYCLES = TURN_CYCLES_DEF
) (
  input logic        clk,
  input logic        rstn,
  robot_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(TURN_CYCLES) + 1;
  localparam logic [DIST_W-1:0] SAFE_V = DIST_W'(SAFE_DIST);
  localparam logic [DIST_W-1:0] WARN_V = DIST_W'(WARN_DIST);
  localparam logic [CNT_W-1:0]  LOAD_V = CNT_W'(TURN_CYCLES - 1);

  state_e     r_state;
  state_e     w_next;
  logic [1:0] r_speed;
  logic       r_turn;
  logic       r_obstacle;
  logic       w_near;
  logic       w_warn;
  logic       w_load;
  logic       w_dec;
  logic       w_zero;

  assign w_near = (bus.dist_v < SAFE_V);
  assign w_warn = (bus.dist_v < WARN_V);

  robot_turn_timer #(.CNT_W(CNT_W), .MAX_V(TURN_CYCLES - 1)) u_timer (
    .clk       (clk),
    .rstn      (rstn),
    .i_load    (w_load),
    .i_load_val(LOAD_V),
    .i_dec     (w_dec),
    .o_zero    (w_zero)
  );

  // Next-state and timer control; a turn retries while the obstacle persists.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_dec  = 1'b0;
    case (r_state)
      IDLE: w_next = FWD;
      FWD: begin
        if (w_near)      w_next = STOP;
        else if (w_warn) w_next = SLOW;
        else             w_next = FWD;
      end
      SLOW: begin
        if (w_near)       w_next = STOP;
        else if (!w_warn) w_next = FWD;
        else              w_next = SLOW;
      end
      STOP: begin
        w_next = TURN;
        w_load = 1'b1;
      end
      TURN: begin
        if (!w_zero) begin
          w_dec  = 1'b1;
          w_next = TURN;
        end else if (w_near) begin
          w_load = 1'b1;
          w_next = TURN;
        end else begin
          w_next = FWD;
        end
      end
      default: w_next = STOP;
    endcase
  end

  // State and output registers; outputs decode the next state so they align with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_speed    <= SPD_HALT;
      r_turn     <= 1'b0;
      r_obstacle <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_speed    <= speed_of(w_next);
      r_turn     <= (w_next == TURN);
      r_obstacle <= w_near;
    end
  end

  assign bus.speed_o    = r_speed;
  assign bus.turn_o     = r_turn;
  assign bus.state_o    = r_state;
  assign bus.obstacle_o = r_obstacle;

`ifdef FORMAL
  robot_ctrl_props u_props (
    .clk(clk), .rstn(rstn), .i_state(r_state), .i_speed(r_speed),
    .i_turn(r_turn), .i_near(w_near)
  );
`endif

endmodule

`ifdef FORMAL
module robot_ctrl_props
  import robot_pkg::*;
(
  input logic       clk,
  input logic       rstn,
  input state_e     i_state,
  input logic [1:0] i_speed,
  input logic       i_turn,
  input logic       i_near
);
  a_no_spd2:   assert property (@(posedge clk) disable iff (!rstn) i_speed != 2'd2);
  a_turn_st:   assert property (@(posedge clk) disable iff (!rstn) i_turn |-> (i_state == TURN));
  a_fwd_near:  assert property (@(posedge clk) disable iff (!rstn)
    (i_state == FWD && i_near) |=> (i_state != FWD));
  c_turn_back: cover property (@(posedge clk) disable iff (!rstn)
    (i_state == TURN) ##1 (i_state == FWD));
endmodule
`endif

// File: tb/tb_robot_ctrl.sv
// Directed self-checking bench for robot_ctrl with hand-computed expectations.
module tb_robot_ctrl;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  robot_ctrl_if #(.DIST_W(16)) bus ();

  robot_ctrl #(
    .DIST_W(16), .SAFE_DIST(100), .WARN_DIST(300), .TURN_CYCLES(8)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int st, input int spd, input int trn, input int obs);
    check({tag, ".state"},    int'(bus.state_o),    st);
    check({tag, ".speed"},    int'(bus.speed_o),    spd);
    check({tag, ".turn"},     int'(bus.turn_o),     trn);
    check({tag, ".obstacle"}, int'(bus.obstacle_o), obs);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rstn       = 1'b0;
    bus.dist_v = 16'd1000;
    step();
    step();
    expect_out("reset", 0, 0, 0, 0);

    rstn = 1'b1;
    step();
    expect_out("idle_to_fwd", 1, 3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("fwd_hold", 1, 3, 0, 0);
    end

    bus.dist_v = 16'd200;
    step();
    expect_out("slow_200", 2, 1, 0, 0);
    bus.dist_v = 16'd300;
    step();
    expect_out("warn_edge_fwd", 1, 3, 0, 0);

    bus.dist_v = 16'd100;
    step();
    expect_out("safe_edge_slow", 2, 1, 0, 0);
    bus.dist_v = 16'd99;
    step();
    expect_out("stop_99", 3, 0, 0, 1);

    bus.dist_v = 16'd500;
    step();
    expect_out("turn_enter", 4, 1, 1, 0);
    for (int i = 0; i < 7; i++) begin
      step();
      expect_out("turn_run", 4, 1, 1, 0);
    end
    step();
    expect_out("turn_exit_fwd", 1, 3, 0, 0);

    bus.dist_v = 16'd50;
    step();
    expect_out("stop_50", 3, 0, 0, 1);

    bus.dist_v = 16'd0;
    step();
    expect_out("retry_enter", 4, 1, 1, 1);
    for (int i = 0; i < 24; i++) begin
      step();
      expect_out("retry_hold", 4, 1, 1, 1);
    end

    // Retry period restarted at the last edge; two more edges puts us in turn cycle 3.
    step();
    step();
    #2;
    rstn = 1'b0;
    #1;
    expect_out("async_reset", 0, 0, 0, 0);
    step();
    expect_out("reset_held", 0, 0, 0, 0);

    rstn = 1'b1;
    #1;
    expect_out("post_release_idle", 0, 0, 0, 0);
    step();
    expect_out("rel_fwd", 1, 3, 0, 1);
    step();
    expect_out("rel_stop", 3, 0, 0, 1);
    bus.dist_v = 16'hFFFF;
    step();
    expect_out("rel_turn", 4, 1, 1, 0);
    for (int i = 0; i < 7; i++) begin
      step();
      expect_out("rel_turn_run", 4, 1, 1, 0);
    end
    step();
    expect_out("allones_fwd", 1, 3, 0, 0);
    step();
    expect_out("allones_hold", 1, 3, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/robot_ctrl.md
Name: robot_ctrl

Overview:
- Obstacle-avoidance motion controller for a small mobile robot.
- Samples a 16-bit distance-sensor value every clock and runs a 5-state FSM: IDLE, FWD, SLOW, STOP, TURN.
- Drives registered motor speed, turn and state outputs to the motor-driver block.
- Sits between the sensor front-end (supplies dist_v) and the motor PWM generator (consumes speed_o/turn_o).

Parameters:
- DIST_W, 16, width of the distance input.
- SAFE_DIST, 100, distance below which the robot must stop.
- WARN_DIST, 300, distance below which the robot slows; must be greater than SAFE_DIST.
- TURN_CYCLES, 8, number of clock cycles spent in one turn manoeuvre; must be at least 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- dist_v  in  DIST_W  unsigned obstacle distance; 0 means contact or closest.
- speed_o  out  2  motor speed code: 0 = halt, 1 = slow, 3 = full; code 2 is never driven.
- turn_o  out  1  1 = rotate in place (turn manoeuvre active).
- state_o  out  3  current FSM state encoding: IDLE=0, FWD=1, SLOW=2, STOP=3, TURN=4.
- obstacle_o  out  1  registered flag, 1 when the sampled dist_v < SAFE_DIST.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rstn). While rstn=0, all outputs are held at their reset values regardless of clk.
- Reset values: state IDLE, speed_o=0, turn_o=0, state_o=0, obstacle_o=0, turn counter=0.
- Comparisons are unsigned, full DIST_W width.
  - near = dist_v < SAFE_DIST
  - warn = dist_v < WARN_DIST
- Transitions are evaluated on every rising edge. Outputs are registered and reflect the new state in the same edge, so the latency from dist_v to the outputs is 1 cycle.
- IDLE → FWD unconditionally on the first edge after rstn deasserts. IDLE is never re-entered except through reset.
- FWD:
  - near → STOP
  - else warn → SLOW
  - else stay in FWD
- SLOW:
  - near → STOP
  - else !warn → FWD
  - else stay in SLOW
- STOP lasts exactly 1 cycle, then goes to TURN. On entry to TURN, the counter is loaded with TURN_CYCLES-1.
- TURN:
  - The counter decrements each cycle.
  - When the counter is 0: !near → FWD; near → reload the counter and stay in TURN (retry the turn).
  - dist_v is ignored while the counter is nonzero.
- Output decode per state:
  - IDLE: speed 0, turn 0
  - FWD: speed 3, turn 0
  - SLOW: speed 1, turn 0
  - STOP: speed 0, turn 0
  - TURN: speed 1, turn 1
- obstacle_o is registered from near every cycle in every non-reset state.
- Boundaries:
  - dist_v == SAFE_DIST counts as not near.
  - dist_v == WARN_DIST counts as not warn.
  - dist_v = 0 counts as near.
  - dist_v = all-ones counts as clear.
- Reset asserted mid-turn aborts immediately to IDLE, and the counter clears.
- Illegal state encodings (5–7) go to STOP on the next edge.
- Formal properties (included under `ifdef FORMAL`):
  - speed_o is never 2.
  - turn_o=1 implies state TURN.
  - FWD is never directly followed by FWD while near was sampled.
  - The counter never exceeds TURN_CYCLES-1.
  - Cover property: reach TURN and return to FWD.

Decomposition:
- Shared package robot_pkg holds:
  - the state enum (IDLE/FWD/SLOW/STOP/TURN, 3 bits)
  - speed code constants SPD_HALT=0, SPD_SLOW=1, SPD_FULL=3
  - default SAFE_DIST/WARN_DIST values
- One natural sub-module: robot_turn_timer, a loadable down-counter with a zero flag, width $clog2(TURN_CYCLES)+1.
- The FSM and output decode stay in robot_ctrl.

Test Plan:
- Reset then dist_v=1000 → cycle 1 after release state_o=1, speed_o=3, turn_o=0; holds while dist_v stays 1000.
- From FWD, dist_v=200 → next edge state_o=2, speed_o=1; then dist_v=300 → state_o=1, speed_o=3 (WARN boundary).
- From FWD, dist_v=50 → STOP (speed 0, obstacle_o=1) for 1 cycle, then TURN (turn_o=1, speed 1) for 8 cycles; with dist_v=500 at counter 0 → FWD.
- Turn retry: hold dist_v=0 throughout → TURN persists in 8-cycle periods, never FWD; obstacle_o stays 1; speed_o is never 2.
- Reset mid-operation: assert rstn=0 during TURN cycle 3, asynchronously between clock edges → outputs go to 0 immediately; on release with dist_v=0 → IDLE, then FWD, then STOP, then TURN.
- dist_v=100 exactly from FWD → SLOW, not STOP; dist_v=99 → STOP.
